// File: rtl/vote_result_reader_if.sv
// Bus between the vote result reader and its environment: mode and candidate
// buttons, the four live vote counts, and the registered result outputs.
interface vote_result_reader_if;
   logic       mode;
   logic       cand1_vote_valid;
   logic       cand2_vote_valid;
   logic       cand3_vote_valid;
   logic       cand4_vote_valid;
   logic [7:0] cand1_vote_recvd;
   logic [7:0] cand2_vote_recvd;
   logic [7:0] cand3_vote_recvd;
   logic [7:0] cand4_vote_recvd;
   logic [7:0] leds;
   logic [1:0] winner;
   logic       winner_valid;
   logic       tie;
   logic [9:0] total;

   modport master (
      output mode,
      output cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
      output cand1_vote_recvd, cand2_vote_recvd, cand3_vote_recvd, cand4_vote_recvd,
      input  leds, winner, winner_valid, tie, total
   );

   modport slave (
      input  mode,
      input  cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
      input  cand1_vote_recvd, cand2_vote_recvd, cand3_vote_recvd, cand4_vote_recvd,
      output leds, winner, winner_valid, tie, total
   );
endinterface

// File: rtl/vote_result_reader.sv
// Read side of the vote counter: stretches a vote acknowledge onto the LEDs in
// voting mode; in result mode scans a snapshot of the counts for winner, tie
// and total, then lets the operator page through individual counts.
module vote_result_reader #(
   parameter int unsigned ACK_CYCLES = 10
) (
   input logic                clock,
   input logic                reset,
   vote_result_reader_if.slave bus_io
);

   localparam int unsigned       AckW    = $clog2(ACK_CYCLES + 1);
   localparam logic [AckW-1:0]   AckLoad = AckW'(ACK_CYCLES);
   localparam logic [AckW-1:0]   AckOne  = AckW'(1);

   typedef enum logic [1:0] {StVote, StScan, StResult} state_e;

   state_e          state_q;
   logic [AckW-1:0] ack_cnt_q;
   logic [1:0]      idx_q;
   logic [7:0]      snap_q [4];
   logic [7:0]      best_q;
   logic [1:0]      best_idx_q;
   logic [1:0]      sel_q;
   logic [3:0]      btn_prev_q;
   logic [7:0]      leds_q;
   logic [1:0]      winner_q;
   logic            winner_valid_q;
   logic            tie_q;
   logic [9:0]      total_q;

   logic [3:0]      btn;
   logic [3:0]      rise;
   logic [1:0]      sel_d;
   logic [7:0]      cur;
   logic [7:0]      scan_best_d;
   logic [1:0]      scan_idx_d;
   logic            scan_tie_d;
   logic [9:0]      scan_total_d;

   assign btn  = {bus_io.cand4_vote_valid, bus_io.cand3_vote_valid,
                  bus_io.cand2_vote_valid, bus_io.cand1_vote_valid};
   assign rise = btn & ~btn_prev_q;

   // Lowest-numbered rising button wins; otherwise keep the current selection.
   always_comb begin
      sel_d = sel_q;
      if (rise[0])      sel_d = 2'd0;
      else if (rise[1]) sel_d = 2'd1;
      else if (rise[2]) sel_d = 2'd2;
      else if (rise[3]) sel_d = 2'd3;
   end

   // One scan step over the snapshot entry selected by idx_q.
   always_comb begin
      cur          = snap_q[idx_q];
      scan_best_d  = best_q;
      scan_idx_d   = best_idx_q;
      scan_tie_d   = tie_q;
      scan_total_d = total_q + {2'b00, cur};
      if (idx_q == 2'd0) begin
         scan_best_d  = cur;
         scan_idx_d   = 2'd0;
         scan_tie_d   = 1'b0;
         scan_total_d = {2'b00, cur};
      end else if (cur > best_q) begin
         scan_best_d = cur;
         scan_idx_d  = idx_q;
         scan_tie_d  = 1'b0;
      end else if (cur == best_q) begin
         scan_tie_d = 1'b1;
      end
   end

   // Main FSM with all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= StVote;
         ack_cnt_q      <= '0;
         idx_q          <= 2'd0;
         for (int i = 0; i < 4; i++) snap_q[i] <= 8'd0;
         best_q         <= 8'd0;
         best_idx_q     <= 2'd0;
         sel_q          <= 2'd0;
         btn_prev_q     <= 4'd0;
         leds_q         <= 8'd0;
         winner_q       <= 2'd0;
         winner_valid_q <= 1'b0;
         tie_q          <= 1'b0;
         total_q        <= 10'd0;
      end else begin
         btn_prev_q <= btn;
         case (state_q)
            StVote: begin
               if (bus_io.mode) begin
                  state_q   <= StScan;
                  idx_q     <= 2'd0;
                  ack_cnt_q <= '0;
                  leds_q    <= 8'd0;
                  snap_q[0] <= bus_io.cand1_vote_recvd;
                  snap_q[1] <= bus_io.cand2_vote_recvd;
                  snap_q[2] <= bus_io.cand3_vote_recvd;
                  snap_q[3] <= bus_io.cand4_vote_recvd;
               end else if (|btn) begin
                  ack_cnt_q <= AckLoad;
                  leds_q    <= 8'hFF;
               end else if (ack_cnt_q != '0) begin
                  ack_cnt_q <= ack_cnt_q - AckOne;
                  leds_q    <= (ack_cnt_q != AckOne) ? 8'hFF : 8'h00;
               end else begin
                  leds_q <= 8'h00;
               end
            end
            StScan: begin
               if (!bus_io.mode) begin
                  // Abort: partial tie/total stay in place but are not valid.
                  state_q <= StVote;
               end else begin
                  best_q     <= scan_best_d;
                  best_idx_q <= scan_idx_d;
                  tie_q      <= scan_tie_d;
                  total_q    <= scan_total_d;
                  idx_q      <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q        <= StResult;
                     winner_valid_q <= 1'b1;
                     winner_q       <= scan_idx_d;
                     sel_q          <= scan_idx_d;
                     leds_q         <= snap_q[scan_idx_d];
                  end
               end
            end
            StResult: begin
               if (!bus_io.mode) begin
                  state_q        <= StVote;
                  winner_valid_q <= 1'b0;
                  leds_q         <= 8'd0;
                  ack_cnt_q      <= '0;
               end else begin
                  sel_q  <= sel_d;
                  leds_q <= snap_q[sel_d];
               end
            end
            default: state_q <= StVote;
         endcase
      end
   end

   assign bus_io.leds         = leds_q;
   assign bus_io.winner       = winner_q;
   assign bus_io.winner_valid = winner_valid_q;
   assign bus_io.tie          = tie_q;
   assign bus_io.total        = total_q;

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader with a cycle-level reference model
// and hand-computed checkpoints.
module tb_vote_result_reader;

   localparam int unsigned Ack = 10;

   logic clock = 1'b0;
   logic reset;
   logic chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   vote_result_reader_if bus ();

   vote_result_reader #(.ACK_CYCLES(Ack)) dut (
      .clock (clock),
      .reset (reset),
      .bus_io(bus)
   );

   always #5 clock = ~clock;

   logic [3:0] btn_now;
   logic [7:0] cnt_now [4];
   assign btn_now    = {bus.cand4_vote_valid, bus.cand3_vote_valid,
                        bus.cand2_vote_valid, bus.cand1_vote_valid};
   assign cnt_now[0] = bus.cand1_vote_recvd;
   assign cnt_now[1] = bus.cand2_vote_recvd;
   assign cnt_now[2] = bus.cand3_vote_recvd;
   assign cnt_now[3] = bus.cand4_vote_recvd;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference results computed over the whole snapshot at once.
   function automatic logic [7:0] max_of(input logic [7:0] s [4]);
      logic [7:0] m = 8'd0;
      for (int i = 0; i < 4; i++) if (s[i] > m) m = s[i];
      return m;
   endfunction

   function automatic int win_of(input logic [7:0] s [4]);
      for (int i = 0; i < 4; i++) if (s[i] == max_of(s)) return i;
      return 0;
   endfunction

   function automatic logic tie_of(input logic [7:0] s [4]);
      int c = 0;
      for (int i = 0; i < 4; i++) if (s[i] == max_of(s)) c++;
      return c > 1;
   endfunction

   function automatic logic [9:0] sum_of(input logic [7:0] s [4]);
      int t = 0;
      for (int i = 0; i < 4; i++) t += int'(s[i]);
      return 10'(t);
   endfunction

   function automatic int first_set(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Model: phase 0 vote, 1 scan, 2 result; m_ago = edges since the last vote.
   int         m_phase, m_n, m_ago;
   logic [7:0] m_snap [4];
   logic [3:0] m_prev;
   logic [7:0] e_leds;
   logic [1:0] e_winner;
   logic       e_wv, e_tie;
   logic [9:0] e_total;

   always @(posedge clock) begin
      if (reset) begin
         m_phase <= 0; m_n <= 0; m_ago <= Ack; m_prev <= 4'd0;
         e_leds <= 8'd0; e_winner <= 2'd0; e_wv <= 1'b0; e_tie <= 1'b0; e_total <= 10'd0;
      end else begin
         m_prev <= btn_now;
         case (m_phase)
            0: begin
               if (bus.mode) begin
                  m_phase <= 1; m_n <= 0; m_snap <= cnt_now; e_leds <= 8'd0; m_ago <= Ack;
               end else if (btn_now != 4'd0) begin
                  m_ago <= 0; e_leds <= 8'hFF;
               end else begin
                  m_ago  <= (m_ago < Ack) ? m_ago + 1 : Ack;
                  e_leds <= (m_ago + 1 < Ack) ? 8'hFF : 8'h00;
               end
            end
            1: begin
               if (!bus.mode) begin
                  m_phase <= 0; e_leds <= 8'd0; m_ago <= Ack;
               end else if (m_n == 3) begin
                  m_phase  <= 2;
                  e_wv     <= 1'b1;
                  e_winner <= 2'(win_of(m_snap));
                  e_tie    <= tie_of(m_snap);
                  e_total  <= sum_of(m_snap);
                  e_leds   <= m_snap[win_of(m_snap)];
               end else begin
                  m_n <= m_n + 1;
               end
            end
            default: begin
               if (!bus.mode) begin
                  m_phase <= 0; e_wv <= 1'b0; e_leds <= 8'd0; m_ago <= Ack;
               end else if ((btn_now & ~m_prev) != 4'd0) begin
                  e_leds <= m_snap[first_set(btn_now & ~m_prev)];
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("model_leds", 32'(bus.leds), 32'(e_leds));
         check("model_winner_valid", 32'(bus.winner_valid), 32'(e_wv));
         if (e_wv) begin
            check("model_winner", 32'(bus.winner), 32'(e_winner));
            check("model_tie", 32'(bus.tie), 32'(e_tie));
            check("model_total", 32'(bus.total), 32'(e_total));
         end
      end
   end

   task automatic set_btn(input logic [3:0] m);
      bus.cand1_vote_valid = m[0];
      bus.cand2_vote_valid = m[1];
      bus.cand3_vote_valid = m[2];
      bus.cand4_vote_valid = m[3];
   endtask

   task automatic set_cnt(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
      bus.cand1_vote_recvd = a;
      bus.cand2_vote_recvd = b;
      bus.cand3_vote_recvd = c;
      bus.cand4_vote_recvd = d;
   endtask

   task automatic pulse(input logic [3:0] m);
      set_btn(m);
      @(negedge clock);
      set_btn(4'd0);
   endtask

   task automatic wait_wv(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.winner_valid && n < 20);
   endtask

   task automatic count_high(output int hi);
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.leds != 8'hFF) break;
         hi++;
         @(negedge clock);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int n, hi;
      reset    = 1'b1;
      bus.mode = 1'($urandom);
      set_btn(4'($urandom));
      set_cnt(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clock);
      bus.mode = 1'($urandom);
      set_btn(4'($urandom));
      @(negedge clock);
      chk_en = 1'b1;
      check("rst_leds", 32'(bus.leds), 32'd0);
      check("rst_wv", 32'(bus.winner_valid), 32'd0);
      check("rst_winner", 32'(bus.winner), 32'd0);
      check("rst_tie", 32'(bus.tie), 32'd0);
      check("rst_total", 32'(bus.total), 32'd0);

      reset    = 1'b0;
      bus.mode = 1'b0;
      set_btn(4'd0);
      repeat (5) @(negedge clock);
      check("idle_leds", 32'(bus.leds), 32'd0);

      // Single ack pulse: exactly Ack cycles of 8'hFF.
      pulse(4'b0010);
      count_high(hi);
      check("ack_len", 32'(hi), 32'd10);

      // Retrigger at the sixth edge: full length again from the second pulse.
      pulse(4'b0010);
      repeat (5) @(negedge clock);
      pulse(4'b0010);
      count_high(hi);
      check("ack_retrig_len", 32'(hi), 32'd10);

      // Clear winner, latency five edges.
      set_cnt(8'd3, 8'd9, 8'd5, 8'd2);
      bus.mode = 1'b1;
      wait_wv(n);
      check("win_latency", 32'(n), 32'd5);
      check("win_winner", 32'(bus.winner), 32'd1);
      check("win_tie", 32'(bus.tie), 32'd0);
      check("win_total", 32'(bus.total), 32'd19);
      check("win_leds", 32'(bus.leds), 32'd9);
      bus.mode = 1'b0;
      @(negedge clock);
      check("exit_wv", 32'(bus.winner_valid), 32'd0);
      check("exit_leds", 32'(bus.leds), 32'd0);

      // Tie; live counts change after entry to prove the snapshot is used.
      set_cnt(8'd7, 8'd4, 8'd7, 8'd0);
      bus.mode = 1'b1;
      @(negedge clock);
      set_cnt(8'd1, 8'd1, 8'd1, 8'd1);
      wait_wv(n);
      check("tie_winner", 32'(bus.winner), 32'd0);
      check("tie_tie", 32'(bus.tie), 32'd1);
      check("tie_total", 32'(bus.total), 32'd18);
      pulse(4'b0100);
      check("sel_c3", 32'(bus.leds), 32'd7);
      pulse(4'b1010);
      check("sel_c2_over_c4", 32'(bus.leds), 32'd4);
      set_btn(4'b0010);
      repeat (4) @(negedge clock);
      check("held_c2", 32'(bus.leds), 32'd4);
      set_btn(4'b1010);
      @(negedge clock);
      check("c4_rise_while_c2_held", 32'(bus.leds), 32'd0);
      set_btn(4'd0);
      bus.mode = 1'b0;
      @(negedge clock);

      // Abort while idx=2 is being processed.
      set_cnt(8'd1, 8'd2, 8'd3, 8'd4);
      bus.mode = 1'b1;
      repeat (3) @(negedge clock);
      bus.mode = 1'b0;
      @(negedge clock);
      check("abort_leds", 32'(bus.leds), 32'd0);
      repeat (6) @(negedge clock);
      check("abort_wv", 32'(bus.winner_valid), 32'd0);
      pulse(4'b0001);
      check("abort_vote_ack", 32'(bus.leds), 32'd255);

      // Saturated counts.
      set_cnt(8'd255, 8'd255, 8'd255, 8'd255);
      bus.mode = 1'b1;
      wait_wv(n);
      check("max_total", 32'(bus.total), 32'd1020);
      check("max_tie", 32'(bus.tie), 32'd1);
      check("max_winner", 32'(bus.winner), 32'd0);
      check("max_leds", 32'(bus.leds), 32'd255);

      // Reset while in RESULT with mode held high, then a fresh scan.
      reset = 1'b1;
      @(negedge clock);
      check("rr_wv", 32'(bus.winner_valid), 32'd0);
      check("rr_leds", 32'(bus.leds), 32'd0);
      check("rr_total", 32'(bus.total), 32'd0);
      reset = 1'b0;
      wait_wv(n);
      check("rr_latency", 32'(n), 32'd5);
      check("rr_total_after", 32'(bus.total), 32'd1020);

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
